// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with 3-sample mid-bit majority vote and single-entry holding register
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx_in      serial line, idle high, asynchronous to clk
//   rx_data    received character, stable while rx_valid
//   rx_valid   character available
//   rx_ready   consumer accepts; transfer on rx_valid && rx_ready
//   parity_err parity mismatch for the held character
//   frame_err  a stop bit sampled low for the held character
//   overrun    one-cycle pulse when a frame completes while the holding register is full
//   busy       receiver FSM not idle
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 1736,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;
  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rxs, prev_q;
  logic [1:0]           hist_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 sample, bit_end, maj, done, load;
  assign rxs = sync_q[SYNC_STAGES-1];
  // hist_q holds rxs from the two previous cycles, so at cnt = MID+1 it carries the MID-1 and MID samples
  assign maj     = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
  assign sample  = cnt_q == CW'(MID + 1);
  assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
  // the frame completes at the last stop bit's sample point, without waiting for the end of that bit
  assign done    = state_q == STOP && sample && idx_q == 4'(STOP_BITS - 1);
  assign load    = done && (!rx_valid_q || rx_ready);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    cnt_d   = (state_q == IDLE || state_q == WAIT_HIGH || bit_end) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (prev_q && !rxs) begin
        state_d = START;
        idx_d   = '0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
      end
      START: begin
        if (sample && maj) state_d = IDLE;
        else if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (sample) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = PARITY != 0 ? PAR : STOP;
          end
        end
      end
      PAR: begin
        // odd parity wants XOR(data, p) = 1, even wants 0
        if (sample) perr_d = ^shift_q ^ maj ^ 1'(PARITY == 1);
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (sample && !maj) ferr_d = 1'b1;
        if (done) state_d = maj ? IDLE : WAIT_HIGH;
        else if (bit_end) idx_d = idx_q + 4'd1;
      end
      WAIT_HIGH: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rx_data_d    = load ? shift_q : rx_data_q;
    parity_err_d = load ? perr_d : parity_err_q;
    frame_err_d  = load ? ferr_d : frame_err_q;
    rx_valid_d   = load || (rx_valid_q && !rx_ready);
    overrun_d    = done && rx_valid_q && !rx_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '1;
      prev_q       <= 1'b1;
      hist_q       <= 2'b11;
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], rx_in};
      prev_q       <= rxs;
      hist_q       <= {hist_q[0], rxs};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame in 8N1 and 7E1 configurations at 16 clocks per bit
module tb_uart_rx_frame;
  localparam int CPB = 16;
  logic clk = 1'b0, rst_n = 1'b0, rxa = 1'b1, rxb = 1'b1, ready = 1'b1;
  logic [7:0] da;
  logic va, pea, fea, ova, ba;
  logic [6:0] db;
  logic vb, peb, feb, ovb, bb;
  int tests = 0, fails = 0, cyc_n = 0;
  int na = 0, nb = 0, ova_n = 0, ta = 0;
  logic [7:0] la;
  logic lpa, lfa;
  logic [6:0] lb;
  logic lpb, lfb;
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_in(rxa), .rx_data(da), .rx_valid(va), .rx_ready(ready),
    .parity_err(pea), .frame_err(fea), .overrun(ova), .busy(ba));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_in(rxb), .rx_data(db), .rx_valid(vb), .rx_ready(ready),
    .parity_err(peb), .frame_err(feb), .overrun(ovb), .busy(bb));
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(negedge clk) begin
    if (va && ready) begin
      na  <= na + 1;
      la  <= da;
      lpa <= pea;
      lfa <= fea;
      ta  <= cyc_n;
    end
    if (vb && ready) begin
      nb  <= nb + 1;
      lb  <= db;
      lpb <= peb;
      lfb <= feb;
    end
    if (ova) ova_n <= ova_n + 1;
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_head(input logic [7:0] d, input int g, output int t0);
    rxa = 1'b0;
    t0 = cyc_n;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxa = d[i];
      if (i == g) begin
        cyc(8);
        rxa = ~d[i];
        cyc(1);
        rxa = d[i];
        cyc(7);
      end else cyc(CPB);
    end
  endtask
  task automatic send_a(input logic [7:0] d);
    int t0;
    send_head(d, -1, t0);
    rxa = 1'b1;
    cyc(CPB);
  endtask
  task automatic send_b(input logic [6:0] d, input logic p);
    rxb = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 7; i++) begin
      rxb = d[i];
      cyc(CPB);
    end
    rxb = p;
    cyc(CPB);
    rxb = 1'b1;
    cyc(CPB);
    cyc(4);
  endtask
  task automatic test_reset;
    cyc(3);
    tests++; if (va !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", va); end
    tests++; if (da !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", da); end
    tests++; if ({pea, fea} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {pea, fea}); end
    tests++; if (ova !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", ova); end
    tests++; if (ba !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", ba); end
    tests++; if ({vb, bb} !== 2'b00) begin fails++; $display("FAIL reset_b got %b want 00", {vb, bb}); end
    rst_n = 1'b1;
    cyc(3);
  endtask
  task automatic test_basic;
    int n0, t0;
    n0 = na;
    send_head(8'hA5, -1, t0);
    rxa = 1'b1;
    cyc(CPB);
    cyc(2);
    tests++; if (na !== n0 + 1) begin fails++; $display("FAIL basic_count got %0d want %0d", na - n0, 1); end
    tests++; if (la !== 8'hA5) begin fails++; $display("FAIL basic_data got %h want a5", la); end
    tests++; if ({lpa, lfa} !== 2'b00) begin fails++; $display("FAIL basic_flags got %b want 00", {lpa, lfa}); end
    tests++; if (ba !== 1'b0) begin fails++; $display("FAIL basic_busy got %b want 0", ba); end
    tests++; if (ta - t0 !== 157) begin fails++; $display("FAIL basic_latency got %0d want 157", ta - t0); end
  endtask
  task automatic test_parity;
    int n0;
    n0 = nb;
    send_b(7'h35, 1'b0);
    tests++; if (nb !== n0 + 1) begin fails++; $display("FAIL par_count1 got %0d want 1", nb - n0); end
    tests++; if (lb !== 7'h35) begin fails++; $display("FAIL par_data1 got %h want 35", lb); end
    tests++; if ({lpb, lfb} !== 2'b00) begin fails++; $display("FAIL par_flags1 got %b want 00", {lpb, lfb}); end
    send_b(7'h35, 1'b1);
    tests++; if (nb !== n0 + 2) begin fails++; $display("FAIL par_count2 got %0d want 2", nb - n0); end
    tests++; if (lb !== 7'h35) begin fails++; $display("FAIL par_data2 got %h want 35", lb); end
    tests++; if ({lpb, lfb} !== 2'b10) begin fails++; $display("FAIL par_flags2 got %b want 10", {lpb, lfb}); end
    tests++; if (ovb !== 1'b0) begin fails++; $display("FAIL par_overrun got %b want 0", ovb); end
  endtask
  task automatic test_glitch;
    int n0, t0;
    n0 = na;
    rxa = 1'b0;
    cyc(3);
    rxa = 1'b1;
    cyc(3);
    tests++; if (ba !== 1'b1) begin fails++; $display("FAIL glitch_start got %b want 1", ba); end
    cyc(30);
    tests++; if (ba !== 1'b0) begin fails++; $display("FAIL glitch_idle got %b want 0", ba); end
    tests++; if (na !== n0) begin fails++; $display("FAIL glitch_count got %0d want 0", na - n0); end
    send_head(8'hB6, 2, t0);
    rxa = 1'b1;
    cyc(CPB);
    cyc(2);
    tests++; if (na !== n0 + 1) begin fails++; $display("FAIL midglitch_count got %0d want 1", na - n0); end
    tests++; if (la !== 8'hB6) begin fails++; $display("FAIL midglitch_data got %h want b6", la); end
  endtask
  task automatic test_break;
    int n0, t0;
    n0 = na;
    send_head(8'h0F, -1, t0);
    rxa = 1'b0;
    cyc(40);
    tests++; if (na !== n0 + 1) begin fails++; $display("FAIL break_count got %0d want 1", na - n0); end
    tests++; if (la !== 8'h0F) begin fails++; $display("FAIL break_data got %h want 0f", la); end
    tests++; if (lfa !== 1'b1) begin fails++; $display("FAIL break_ferr got %b want 1", lfa); end
    tests++; if (ba !== 1'b1) begin fails++; $display("FAIL break_wait got %b want 1", ba); end
    rxa = 1'b1;
    cyc(6);
    tests++; if (ba !== 1'b0) begin fails++; $display("FAIL break_release got %b want 0", ba); end
    send_a(8'h3C);
    cyc(2);
    tests++; if (na !== n0 + 2) begin fails++; $display("FAIL break_next_count got %0d want 2", na - n0); end
    tests++; if ({la, lpa, lfa} !== {8'h3C, 2'b00}) begin fails++; $display("FAIL break_next got %h/%b want 3c/00", la, {lpa, lfa}); end
  endtask
  task automatic test_back_to_back;
    int n0, o0;
    n0 = na;
    o0 = ova_n;
    ready = 1'b0;
    send_a(8'h11);
    send_a(8'h22);
    cyc(2);
    tests++; if (va !== 1'b1) begin fails++; $display("FAIL ovr_valid got %b want 1", va); end
    tests++; if (da !== 8'h11) begin fails++; $display("FAIL ovr_held got %h want 11", da); end
    tests++; if (ova_n !== o0 + 1) begin fails++; $display("FAIL ovr_pulses got %0d want 1", ova_n - o0); end
    ready = 1'b1;
    cyc(1);
    tests++; if (na !== n0 + 1) begin fails++; $display("FAIL ovr_xfer got %0d want 1", na - n0); end
    tests++; if (la !== 8'h11) begin fails++; $display("FAIL ovr_xfer_data got %h want 11", la); end
    tests++; if (va !== 1'b0) begin fails++; $display("FAIL ovr_drop got %b want 0", va); end
  endtask
  task automatic test_reset_mid;
    int n0;
    n0 = na;
    rxa = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rxa = (8'h5A >> i) & 8'h01;
      cyc(CPB);
    end
    rst_n = 1'b0;
    cyc(2);
    tests++; if ({va, ba} !== 2'b00) begin fails++; $display("FAIL rstmid_state got %b want 00", {va, ba}); end
    tests++; if (da !== 8'h00) begin fails++; $display("FAIL rstmid_data got %h want 00", da); end
    rxa = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    send_a(8'hC3);
    cyc(2);
    tests++; if (na !== n0 + 1) begin fails++; $display("FAIL rstmid_count got %0d want 1", na - n0); end
    tests++; if ({la, lpa, lfa} !== {8'hC3, 2'b00}) begin fails++; $display("FAIL rstmid_data2 got %h/%b want c3/00", la, {lpa, lfa}); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_glitch;
    test_break;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receive engine, replacing the fixed 8N1 receiver in the FPGA order-entry path. It accepts an asynchronous serial line and supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. Each bit is sampled by 3-sample majority vote at mid-bit. Completed characters go to downstream packet logic through a single-entry valid/ready holding register, with per-character parity/framing flags and an overrun pulse.

## Interface
- CLKS_PER_BIT, 1736, clk cycles per bit (200 MHz / 115200); legal ≥ 8
- DATA_BITS, 8, data bits per frame, 5–9, LSB first
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- SYNC_STAGES, 2, input synchroniser depth, ≥ 2
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- rx_in  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  DATA_BITS  received character, stable while rx_valid
- rx_valid  output  1  character available
- rx_ready  input  1  consumer accepts; transfer on rx_valid && rx_ready
- parity_err  output  1  parity mismatch for the held character (0 when PARITY = 0)
- frame_err  output  1  a stop bit sampled low for the held character
- overrun  output  1  one-cycle pulse: a frame completed while the holding register was full
- busy  output  1  FSM not in IDLE

## Operation
- rx_in passes through SYNC_STAGES flops, all reset to 1. All logic uses the synchronised signal rxs.
- MID = CLKS_PER_BIT/2 (floor). One bit counter, cnt, runs 0..CLKS_PER_BIT-1.
- Each bit is sampled at cnt = MID-1, MID and MID+1. The bit value is the majority of the three. It is registered at cnt = MID+1.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
  - IDLE: a falling edge on rxs (previous 1, current 0) -> START with cnt = 0, bit index = 0.
  - START: majority = 1 -> IDLE (glitch, no output, no flags). Majority = 0 -> continue. At cnt = CLKS_PER_BIT-1 -> DATA, cnt = 0.
  - DATA: shift in the majority bit at the bit index, LSB first. At the end of bit DATA_BITS-1 -> PAR if PARITY ≠ 0, else STOP.
  - PAR: compare the majority bit with the computed parity. Odd: XOR(data, p) must be 1. Even: XOR must be 0. Then -> STOP.
  - STOP: a majority of 0 in any stop bit sets the frame error. Frame completes at the MID+1 sample of the last stop bit. Do not wait for the end of that bit. If the last stop bit is 0 -> WAIT_HIGH, else -> IDLE.
  - WAIT_HIGH: stay until rxs = 1, then -> IDLE. This covers break conditions and prevents false starts.
- On frame completion:
  - If rx_valid = 0, or rx_ready = 1 in the same cycle: load rx_data, parity_err and frame_err; set rx_valid.
  - Otherwise: drop the new frame, keep the held data and flags, pulse overrun.
- Frames with errors are still delivered, with their flags set.
- rx_valid clears on transfer unless a new frame loads in the same cycle. In that case rx_valid stays 1 and the new data replaces the old.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0, FSM = IDLE, synchroniser = all 1.
- Reset takes effect mid-frame: the partial character is discarded and the holding register is cleared.
- START is entered SYNC_STAGES+1 cycles after the rx_in falling edge, not counting synchroniser metastability.
- rx_valid rises 1 cycle after the final-stop-bit sample. That is (1+DATA_BITS+P+STOP_BITS-1)·CLKS_PER_BIT + MID+2 cycles after entering START, where P = 1 if PARITY ≠ 0, else 0.
- A new start edge is detected no earlier than the cycle after returning to IDLE. Back-to-back frames with zero idle time are supported.
- overrun is high for exactly 1 cycle per dropped frame. It never coincides with a load.

## Test plan
- CLKS_PER_BIT = 16, 8N1, rx_ready = 1: send 0xA5 -> one rx_valid pulse, rx_data = 0xA5, both error flags 0, busy returns to 0.
- PARITY = 2, DATA_BITS = 7: send 0x35 with parity bit 0, then again with parity bit 1 -> first delivered clean, second delivered with parity_err = 1.
- A 3-cycle low glitch on idle rx_in -> no rx_valid, FSM returns to IDLE. A 1-cycle mid-bit glitch inside a data bit -> majority vote rejects it, data correct.
- Stop bit held low for 40 cycles (break) -> frame_err = 1. FSM stays in WAIT_HIGH until the line goes high. A following 0x3C is received clean.
- rx_ready = 0, send 0x11 then 0x22 back-to-back -> rx_data holds 0x11, one overrun pulse. Raise rx_ready -> 0x11 transfers, rx_valid drops.
- Deassert rst_n during DATA of 0x5A, release, send 0xC3 -> outputs 0 during reset, then only 0xC3 is delivered.
